remote_comm: RTL and testbench

//  Host-side Bluetooth/UART command source for the Knight's Tour robot link.

---
 rtl/remote_comm_pkg.sv | 6 +
 rtl/remote_comm_if.sv | 10 +
 rtl/remote_comm_uart_trx.sv | 81 ++++++++
 rtl/remote_comm.sv | 46 ++++
 tb/tb_remote_comm.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared FSM states and framing constants for the host command link
package remote_comm_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} rc_state_t;
  localparam int BITS_PER_FRAME = 10;
  localparam int DEFAULT_BAUD_DIV = 2604;
endpackage

// File: rtl/remote_comm_if.sv
// remote_comm_if: command request and response handshake between host logic and remote_comm
interface remote_comm_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  modport master(output cmd, send_cmd, input cmd_sent, resp_rdy, resp);
  modport slave(input cmd, send_cmd, output cmd_sent, resp_rdy, resp);
endinterface

// File: rtl/remote_comm_uart_trx.sv
// uart_trx: 8N1 transmitter and mid-bit sampling receiver sharing one baud divisor
module uart_trx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic       rdy,
  output logic [7:0] rx_data
);
  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  LAST = 4'(BITS_PER_FRAME - 1);
  logic [9:0]  tx_shift;
  logic [11:0] tx_baud, rx_baud;
  logic [3:0]  tx_cnt, rx_cnt;
  logic        tx_busy, tx_tick, rx_busy, rx_tick, rx_s1, rx_s2, rx_q;
  logic [7:0]  rx_shift;
  assign tx_tick = tx_busy && tx_baud == FULL;
  assign rx_tick = rx_busy && rx_baud == '0;
  assign TX = tx_shift[0];
  // Shifting ones in from the top leaves the line idle high once the frame is out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_cnt   <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= tx_tick && tx_cnt == LAST;
      if (trmt) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_baud  <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        tx_baud <= tx_tick ? '0 : tx_baud + 1'b1;
        if (tx_tick) begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_cnt   <= tx_cnt + 1'b1;
          tx_busy  <= tx_cnt != LAST;
        end
      end
    end
  end
  // Ten samples per frame: start, eight data, stop; start falls out of the 8-bit shifter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rx_q, rx_s2, rx_s1} <= '1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      {rx_q, rx_s2, rx_s1} <= {rx_s2, rx_s1, RX};
      rdy <= rx_tick && rx_cnt == LAST;
      if (!rx_busy && rx_q && !rx_s2) begin
        rx_busy <= 1'b1;
        rx_baud <= HALF;
        rx_cnt  <= '0;
      end else if (rx_busy) begin
        rx_baud <= rx_tick ? FULL : rx_baud - 1'b1;
        if (rx_tick) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_cnt   <= rx_cnt + 1'b1;
          rx_busy  <= rx_cnt != LAST;
          if (rx_cnt == LAST) rx_data <= rx_shift;
        end
      end
    end
  end
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first) and captures the 8-bit response.
// RESP_CLR_ON_SEND_EN makes resp_rdy a level cleared by the next accepted send_cmd instead of a pulse.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  output logic         TX,
  remote_comm_if.slave bus
);
  rc_state_t  state, nxt;
  logic [7:0] cmd_lo, tx_data;
  logic       trmt, tx_done, rdy, accept;
  assign accept = state == IDLE && bus.send_cmd;
  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk, .rst_n, .trmt, .tx_data, .tx_done, .TX, .RX, .rdy, .rx_data(bus.resp)
  );
  // High byte goes straight from the port so the first frame starts the clock after accept
  always_comb begin
    nxt     = state;
    trmt    = accept || (state == HIGH && tx_done);
    tx_data = accept ? bus.cmd[15:8] : cmd_lo;
    if (accept) nxt = HIGH;
    else if (tx_done) nxt = state == HIGH ? LOW : state == LOW ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_lo       <= '0;
      bus.cmd_sent <= 1'b0;
      bus.resp_rdy <= 1'b0;
    end else begin
      state        <= nxt;
      cmd_lo       <= accept ? bus.cmd[7:0] : cmd_lo;
      bus.cmd_sent <= accept ? 1'b0 : (state == LOW && tx_done) ? 1'b1 : bus.cmd_sent;
`ifdef RESP_CLR_ON_SEND_EN
      bus.resp_rdy <= rdy || (bus.resp_rdy && !accept);
`else
      bus.resp_rdy <= rdy;
`endif
    end
  end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed scoreboard bench decoding TX frames and injecting RX responses
module tb_remote_comm;
  import remote_comm_pkg::*;
  localparam int BD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  remote_comm_if bus();
  remote_comm #(.BAUD_DIV(BD)) dut (.clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_tx_byte(output logic [7:0] b);
    int n = 0;
    b = '0;
    while (TX !== 1'b0 && n < 16 * BD) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", {31'd0, TX}, 32'd0);
    repeat (BD / 2) @(negedge clk);
    check("tx_start_mid", {31'd0, TX}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BD) @(negedge clk);
    check("tx_stop", {31'd0, TX}, 32'd1);
  endtask

  task automatic tx_expect(input int nb);
    logic [7:0] b, e;
    for (int k = 0; k < nb; k++) begin
      get_tx_byte(b);
      got.push_back(b);
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      check("tx_byte", {24'd0, b}, {24'd0, e});
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_resp(input logic [7:0] e);
    int n = 0;
    while (bus.resp_rdy !== 1'b1 && n < 20 * BD) begin
      @(negedge clk);
      n++;
    end
    check("resp_rdy", {31'd0, bus.resp_rdy}, 32'd1);
    check("resp", {24'd0, bus.resp}, {24'd0, e});
  endtask

  task automatic start_cmd(input logic [15:0] c);
    @(negedge clk);
    bus.cmd = c;
    bus.send_cmd = 1'b1;
    @(negedge clk);
    bus.send_cmd = 1'b0;
    check("cmd_sent_clr", {31'd0, bus.cmd_sent}, 32'd0);
  endtask

  task automatic wait_sent;
    int n = 1;
    while (bus.cmd_sent !== 1'b1 && n < 20 * BD + 10) begin
      @(negedge clk);
      n++;
    end
    check("cmd_sent_lat", {31'd0, bus.cmd_sent === 1'b1 && n >= 20 * BD && n <= 20 * BD + 5}, 32'd1);
  endtask

  initial begin
    logic all_hi;
    bus.cmd = '0;
    bus.send_cmd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd_sent", {31'd0, bus.cmd_sent}, 32'd0);
    check("rst_resp_rdy", {31'd0, bus.resp_rdy}, 32'd0);
    check("rst_resp", {24'd0, bus.resp}, 32'd0);
    check("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    rst_n = 1'b1;

    exp_q.push_back(8'h20);
    exp_q.push_back(8'h01);
    start_cmd(16'h2001);
    fork
      tx_expect(2);
      wait_sent();
    join
    check("wrapper_cmd", {16'd0, got[0], got[1]}, 32'h2001);
    got.delete();
    fork
      send_rx(8'hA5);
      wait_resp(8'hA5);
    join

    exp_q.push_back(8'h20);
    exp_q.push_back(8'h01);
    start_cmd(16'h2001);
    fork
      tx_expect(2);
      wait_sent();
      begin
        repeat (3) @(negedge clk);
        bus.cmd = 16'hFFFF;
        repeat (5 * BD) @(negedge clk);
        bus.send_cmd = 1'b1;
        @(negedge clk);
        bus.send_cmd = 1'b0;
      end
    join
    all_hi = 1'b1;
    repeat (12 * BD) begin
      @(negedge clk);
      all_hi &= TX;
    end
    check("no_extra_frame", {31'd0, all_hi}, 32'd1);
    got.delete();

    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    start_cmd(16'h1234);
    fork
      tx_expect(2);
      wait_sent();
      begin
        repeat (3 * BD) @(negedge clk);
        send_rx(8'h5A);
      end
      wait_resp(8'h5A);
    join
    got.delete();

    start_cmd(16'h00FF);
    repeat (3 * BD) @(negedge clk);
    check("tx_mid_frame", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'd0, TX}, 32'd1);
    check("abort_cmd_sent", {31'd0, bus.cmd_sent}, 32'd0);
    check("abort_state", {30'd0, dut.state}, {30'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    start_cmd(16'h0000);
    fork
      tx_expect(2);
      wait_sent();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
